// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: serialises signed left/right sample pairs onto an I2S link (bclk, lrclk, sdata)
// Ports: system_clock/reset (async, active-low), enable (link run);
//   left_sample/right_sample/sample_valid/sample_ready: one-entry holding buffer handshake;
//   bclk/lrclk/sdata: I2S serial outputs; frame_start/underrun: one-cycle frame load pulses.
module i2s_sample_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_start,
  output logic                    underrun
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int FW = 2 * SLOT_WIDTH;
  localparam int KW = $clog2(FW);
  logic [DW-1:0] div_cnt;
  logic [KW-1:0] k, k_next;
  logic [SLOT_WIDTH-1:0] left_word, right_word;
  logic [FW-1:0] shreg, frame_word;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
  logic hold_full, accept, div_wrap, fall, load;
  assign sample_ready = !hold_full;
  assign accept = sample_valid && !hold_full;
  assign div_wrap = div_cnt == DW'(BCLK_DIV - 1);
  assign fall = enable && div_wrap && bclk;
  assign load = fall && k == KW'(FW - 1);
  assign k_next = load ? '0 : k + KW'(1);
  // samples sit left-aligned in their slots with zero padding below
  assign left_word = SLOT_WIDTH'(hold_l) << (SLOT_WIDTH - SAMPLE_WIDTH);
  assign right_word = SLOT_WIDTH'(hold_r) << (SLOT_WIDTH - SAMPLE_WIDTH);
  assign frame_word = hold_full ? {left_word, right_word} : '0;
  always_ff @(posedge system_clock or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      bclk <= 1'b0;
      k <= KW'(FW - 1);
      lrclk <= 1'b0;
      sdata <= 1'b0;
      shreg <= '0;
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_start <= load;
      underrun <= load && !hold_full;
      if (accept) begin
        hold_full <= 1'b1;
        hold_l <= left_sample;
        hold_r <= right_sample;
      end else if (load) hold_full <= 1'b0;
      if (!enable) begin
        div_cnt <= '0;
        bclk <= 1'b0;
        k <= KW'(FW - 1);
        lrclk <= 1'b0;
        sdata <= 1'b0;
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
        if (div_wrap) bclk <= !bclk;
        if (fall) begin
          k <= k_next;
          // word select switches one bit ahead of the slot it announces
          lrclk <= k_next >= KW'(SLOT_WIDTH - 1) && k_next <= KW'(FW - 2);
          sdata <= load ? frame_word[FW-1] : shreg[FW-1];
          shreg <= (load ? frame_word : shreg) << 1;
        end
      end
    end
endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: self-checking bench for i2s_sample_tx against a cycle-count reference model
module tb_i2s_sample_tx;
  localparam int SW = 24, SL = 32, D = 2, FW = 2 * SL, P = 2 * D * FW;
  logic clk = 0, rst_n = 0, en = 0, valid = 0;
  logic [SW-1:0] l_in = '0, r_in = '0;
  logic ready, bclk, lrclk, sdata, fs, ur;
  int errs = 0, checks = 0;
  int n, e, idx, rcount;
  bit m_full, bp, pre;
  logic [SW-1:0] m_l, m_r;
  logic [FW-1:0] m_word;
  logic [5:0] m_exp;
  localparam logic [SW-1:0] AL = 24'h123456, AR = 24'hFEDCBA, BL = 24'h89ABCD, BR = 24'h013579;

  i2s_sample_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(D)) dut (
    .system_clock(clk), .reset(rst_n), .enable(en),
    .left_sample(l_in), .right_sample(r_in), .sample_valid(valid),
    .sample_ready(ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_start(fs), .underrun(ur));

  always #5 clk = ~clk;

  function automatic logic [5:0] dut_out();
    return {ready, bclk, lrclk, sdata, fs, ur};
  endfunction

  function automatic logic [FW-1:0] mkw(logic [SW-1:0] l, logic [SW-1:0] r);
    return {l, {(SL-SW){1'b0}}, r, {(SL-SW){1'b0}}};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_full = 0; m_word = '0; m_exp = 6'b100000;
  endtask

  // reference: n counts enabled edges; loads happen every P edges starting at edge 2D,
  // and bit k of the frame is shown after the (k+1)-th BCLK fall since the load
  task automatic model_step();
    bit acc, ld, was_full;
    int j, k;
    acc = valid && !m_full;
    was_full = m_full;
    n = en ? n + 1 : 0;
    ld = en && n >= 2 * D && (n - 2 * D) % P == 0;
    if (ld) begin
      m_word = was_full ? mkw(m_l, m_r) : '0;
      m_full = 0;
    end
    if (acc) begin
      m_full = 1; m_l = l_in; m_r = r_in;
    end
    j = n / (2 * D);
    m_exp = '0;
    m_exp[5] = !m_full;
    m_exp[4] = en && (n / D) % 2 == 1;
    if (en && j > 0) begin
      k = (j - 1) % FW;
      m_exp[3] = k >= SL - 1 && k <= FW - 2;
      m_exp[2] = m_word[FW-1-k];
    end
    m_exp[1] = ld;
    m_exp[0] = ld && !was_full;
  endtask

  task automatic cyc(int cnt = 1);
    repeat (cnt) begin
      pre = ready;
      @(posedge clk);
      model_step();
      #1;
      check("outputs", 64'(dut_out()), 64'(m_exp));
      e++;
      if (bp) begin
        rcount += int'(ready);
        if (valid && pre) begin
          idx++;
          l_in = idx[0] ? BL : AL;
          r_in = idx[0] ? BR : AR;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; valid = 0; bp = 0;
    model_reset();
    #1 check("reset", 64'(dut_out()), 64'(6'b100000));
    @(negedge clk);
    rst_n = 1;
    e = 0;
  endtask

  task automatic decode(output logic [FW-1:0] w);
    w[FW-1] = sdata;
    for (int i = FW - 2; i >= 0; i--) begin
      cyc(2 * D);
      w[i] = sdata;
    end
  endtask

  typedef struct {int n; logic valid; logic [5:0] exp;} vec_t;

  initial begin
    vec_t tbl[$];
    logic [FW-1:0] w;
    int ones, fsc, urc;
    tbl.push_back('{1, 1'b1, 6'b000000});
    tbl.push_back('{2, 1'b1, 6'b010000});
    tbl.push_back('{3, 1'b1, 6'b010000});
    tbl.push_back('{4, 1'b1, 6'b100110});
    tbl.push_back('{5, 1'b1, 6'b000100});
    tbl.push_back('{6, 1'b1, 6'b010100});
    tbl.push_back('{8, 1'b1, 6'b000000});
    tbl.push_back('{96, 1'b1, 6'b000100});
    tbl.push_back('{100, 1'b1, 6'b000000});
    tbl.push_back('{127, 1'b1, 6'b010000});
    tbl.push_back('{128, 1'b1, 6'b001000});
    tbl.push_back('{132, 1'b1, 6'b001000});
    tbl.push_back('{136, 1'b1, 6'b001100});
    tbl.push_back('{220, 1'b1, 6'b001100});
    tbl.push_back('{224, 1'b1, 6'b001000});
    tbl.push_back('{256, 1'b1, 6'b000000});
    tbl.push_back('{260, 1'b1, 6'b100110});
    tbl.push_back('{261, 1'b1, 6'b000100});
    idx = 0; rcount = 0; bp = 0;

    do_reset();
    en = 1; l_in = 24'h800001; r_in = 24'h7FFFFE;
    foreach (tbl[i]) begin
      valid = tbl[i].valid;
      while (e < tbl[i].n) cyc();
      check("clean_frame", 64'(dut_out()), 64'(tbl[i].exp));
    end

    valid = 0;
    while (e < 771) cyc();
    ones = 0; fsc = 0; urc = 0;
    while (e < 1283) begin
      cyc();
      ones += int'(sdata); fsc += int'(fs); urc += int'(fs && ur);
    end
    check("underrun_pulses", 64'(urc), 64'd2);
    check("underrun_frame_start", 64'(fsc), 64'd2);
    check("underrun_silence", 64'(ones), 64'd0);

    do_reset();
    en = 1;
    while (e < 259) cyc();
    valid = 1; l_in = 24'hA5C3F1; r_in = 24'h5A3C0E;
    cyc();
    valid = 0;
    check("simul_underrun", 64'({fs, ur}), 64'(2'b11));
    check("simul_ready", 64'(ready), 64'd0);
    ones = 0;
    while (e < 515) begin
      cyc();
      ones += int'(sdata);
    end
    check("simul_silent", 64'(ones), 64'd0);
    cyc();
    check("simul_load", 64'({fs, ur}), 64'(2'b10));
    decode(w);
    check("simul_pair", 64'(w), 64'(mkw(24'hA5C3F1, 24'h5A3C0E)));

    do_reset();
    en = 1; bp = 1; idx = 0; valid = 1; l_in = AL; r_in = AR;
    while (e < 256) cyc();
    rcount = 0;
    while (e < 516) cyc();
    check("bp_load", 64'(fs), 64'd1);
    decode(w);
    check("bp_frame_a", 64'(w), 64'(mkw(AL, AR)));
    while (e < 772) cyc();
    decode(w);
    check("bp_frame_b", 64'(w), 64'(mkw(BL, BR)));
    check("bp_ready_cycles", 64'(rcount), 64'd3);
    check("bp_accepted", 64'(idx), 64'd5);

    while (e < 1204) cyc();
    check("pre_dis_lrclk", 64'(lrclk), 64'd1);
    en = 0;
    cyc();
    check("dis_outputs", 64'({bclk, lrclk, sdata}), 64'd0);
    cyc(6);
    check("dis_hold_kept", 64'(ready), 64'd0);
    en = 1;
    cyc(D - 1);
    check("reen_bclk_low", 64'(bclk), 64'd0);
    cyc();
    check("reen_bclk_rise", 64'(bclk), 64'd1);
    cyc(D);
    check("reen_load", 64'({fs, ur}), 64'(2'b10));
    decode(w);
    check("reen_frame", 64'(w), 64'(mkw(BL, BR)));

    cyc(3);
    check("pre_reset_full", 64'(ready), 64'd0);
    #2;
    rst_n = 0; bp = 0; valid = 0;
    model_reset();
    #1 check("async_reset", 64'(dut_out()), 64'(6'b100000));
    @(negedge clk);
    rst_n = 1; en = 1;
    cyc(2 * D);
    check("post_reset_underrun", 64'({fs, ur}), 64'(2'b11));

    do_reset();
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en = !en;
      valid = $urandom_range(0, 3) == 0;
      l_in = SW'($urandom);
      r_in = SW'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
